nes_controller_emulator: RTL

Device-side NES controller model that emulates the controller's 4021 parallel-in/serial-out shift register. It responds to the console or host's latch and clock lines and returns an 8-bit button snapshot serially on the data line, with pressed buttons driven low. It sits between a local button source (switches, a UART bridge, or a test pattern) and the external NES port pins. It must interoperate with our existing NES host reader.

---
 rtl/nes_pkg.sv | 22 ++
 rtl/nes_controller_emulator_if.sv | 17 +
 rtl/nes_sync_edge.sv | 32 +++
 rtl/nes_controller_emulator.sv | 90 +++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// nes_pkg: shared NES controller bit mapping, frame size and emulator state encoding
//   BTN_A..BTN_RIGHT : bit positions of each button in the 8-bit button word
//   NES_BUTTON_COUNT : bits per controller frame
//   nes_state_t      : emulator FSM states
package nes_pkg;
   localparam int BTN_A            = 0;
   localparam int BTN_B            = 1;
   localparam int BTN_SELECT       = 2;
   localparam int BTN_START        = 3;
   localparam int BTN_UP           = 4;
   localparam int BTN_DOWN         = 5;
   localparam int BTN_LEFT         = 6;
   localparam int BTN_RIGHT        = 7;
   localparam int NES_BUTTON_COUNT = 8;

   typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} nes_state_t;

   // Pressed buttons pull the line low, so the wire image is the inverted button word.
   function automatic logic [NES_BUTTON_COUNT-1:0] wire_image(input logic [NES_BUTTON_COUNT-1:0] btn);
      return ~btn;
   endfunction
endpackage

// File: rtl/nes_controller_emulator_if.sv
// nes_controller_emulator_if: NES port pins plus local button source and status
//   nesLatch, nesClk : host-driven pins (async to clk)
//   buttons          : live button state, 1 = pressed
//   nesData          : serial data back to host, active-low per button
//   pollDone         : one-cycle pulse after the 8th bit
//   bitIndex         : accepted nesClk rises since latch fell (0..8)
interface nes_controller_emulator_if;
   logic       nesLatch;
   logic       nesClk;
   logic [7:0] buttons;
   logic       nesData;
   logic       pollDone;
   logic [3:0] bitIndex;

   modport master (output nesLatch, nesClk, buttons, input nesData, pollDone, bitIndex);
   modport slave  (input nesLatch, nesClk, buttons, output nesData, pollDone, bitIndex);
endinterface

// File: rtl/nes_sync_edge.sv
// nes_sync_edge: multi-flop synchronizer for one async pin with rise/fall pulse detection
//   i_pin   : asynchronous input
//   o_level : synchronized level
//   o_rise  : one-cycle pulse on a synchronized 0->1 transition
//   o_fall  : one-cycle pulse on a synchronized 1->0 transition
module nes_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = o_level & ~r_prev;
   assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/nes_controller_emulator.sv
// nes_controller_emulator: device-side NES controller (4021 shift register model)
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of nes_controller_emulator_if (pins, buttons, status)
module nes_controller_emulator
   import nes_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter bit FILL_LEVEL     = 1'b1,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                     clk,
   input  logic                     reset,
   nes_controller_emulator_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          w_latch_lvl, w_latch_rise, w_latch_fall;
   logic          w_clk_lvl, w_clk_rise, w_clk_fall;
   logic          w_unused;
   nes_state_t    r_state;
   logic [7:0]    r_shift;
   logic          r_data;
   logic          r_poll;
   logic [3:0]    r_idx;
   logic [TW-1:0] r_to;

   nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch (
      .clk(clk), .reset(reset), .i_pin(bus.nesLatch),
      .o_level(w_latch_lvl), .o_rise(w_latch_rise), .o_fall(w_latch_fall)
   );

   nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk (
      .clk(clk), .reset(reset), .i_pin(bus.nesClk),
      .o_level(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
   );

   // Latch is level-sensitive and nesClk falls are don't-care.
   assign w_unused = ^{w_latch_rise, w_clk_lvl, w_clk_fall};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= 8'hFF;
         r_data  <= 1'b1;
         r_poll  <= 1'b0;
         r_idx   <= '0;
         r_to    <= '0;
      end else begin
         r_poll <= 1'b0;
         // A high latch overrides every state and swallows a coincident clock edge.
         if (w_latch_lvl) begin
            r_state <= LOADED;
            r_shift <= wire_image(bus.buttons);
            r_data  <= ~bus.buttons[BTN_A];
            r_idx   <= '0;
            r_to    <= '0;
         end else begin
            case (r_state)
               LOADED: if (w_latch_fall) r_state <= SHIFT;
               SHIFT: begin
                  if (w_clk_rise) begin
                     r_shift <= {FILL_LEVEL, r_shift[7:1]};
                     r_idx   <= r_idx + 4'd1;
                     r_to    <= '0;
                     if (r_idx == 4'(NES_BUTTON_COUNT - 1)) begin
                        r_data  <= FILL_LEVEL;
                        r_poll  <= 1'b1;
                        r_state <= DONE;
                     end else begin
                        r_data <= r_shift[1];
                     end
                  end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
                     r_state <= IDLE;
                     r_data  <= FILL_LEVEL;
                     r_idx   <= '0;
                     r_to    <= '0;
                  end else begin
                     r_to <= r_to + 1'b1;
                  end
               end
               default: r_data <= FILL_LEVEL;
            endcase
         end
      end
   end

   assign bus.nesData  = r_data;
   assign bus.pollDone = r_poll;
   assign bus.bitIndex = r_idx;
endmodule
